// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the execute stage with the
// iterative RV32M multiply/divide unit.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  // Encoding follows the RV32M funct3 field.
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Division by zero: every quotient bit takes this value (all-ones).
  localparam logic DIV_ZERO_QUOT_BIT = 1'b1;
  // Signed overflow: quotient is the most negative value (this MSB, rest 0),
  // remainder has every bit equal to OVF_REM_BIT.
  localparam logic OVF_QUOT_MSB = 1'b1;
  localparam logic OVF_REM_BIT  = 1'b0;

  function automatic logic op_is_mul(input md_op_e op);
    return op inside {MUL, MULH, MULHSU, MULHU};
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/ex_stage_md_if.sv
// ex_stage_md_if: ID/EX bundle feeding the execute stage. The master side
// (ID/EX register) drives operands and control; EX answers with busy.
interface ex_stage_md_if
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NFWD  = 2,
  parameter int RADDR = 5
) ();
  localparam int SELW = $clog2(NFWD + 1);

  logic                 valid;
  logic                 busy;
  logic [XLEN-1:0]      rs1;
  logic [XLEN-1:0]      rs2;
  logic [XLEN-1:0]      imm;
  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      pc4;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [SELW-1:0]      a_fwd_sel;
  logic [SELW-1:0]      b_fwd_sel;
  logic                 a_sel;
  logic                 b_sel;
  alu_op_e              alu_op;
  logic                 md_en;
  md_op_e               md_op;
  logic                 br_un;
  logic [RADDR-1:0]     rd;
  logic                 regwen;
  logic                 memrw;
  logic [1:0]           wbsel;

  modport master (
    output valid, rs1, rs2, imm, pc, pc4, fwd_data, a_fwd_sel, b_fwd_sel,
           a_sel, b_sel, alu_op, md_en, md_op, br_un, rd, regwen, memrw, wbsel,
    input  busy
  );

  modport slave (
    input  valid, rs1, rs2, imm, pc, pc4, fwd_data, a_fwd_sel, b_fwd_sel,
           a_sel, b_sel, alu_op, md_en, md_op, br_un, rd, regwen, memrw, wbsel,
    output busy
  );

endinterface

// File: rtl/md_unit.sv
// md_unit: RV32M multiply/divide. Operands are reduced to magnitudes on
// acceptance, iterated one bit per cycle (shift-add multiply, restoring
// divide) and the sign is restored in DONE.
// Build option EX_FAST_MUL_EN: multiplies become single-cycle combinational.
module md_unit
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            md_en_i,
  input  md_op_e          md_op_i,
  input  logic            flush_i,
  input  logic            enable_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_o
);
  localparam int CNTW = $clog2(XLEN + 1);

  md_state_e         state_q, state_d;
  logic [CNTW-1:0]   cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  md_op_e            op_q;
  logic              neg_q, div_zero_q, ovf_q;

  logic              sa, sb, is_mul, is_rem, ovf_in, start, fast;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, rem_shift, rem_diff;
  logic [2*XLEN-1:0] prod_fix, fast_fix;
  logic [XLEN-1:0]   q_fix, r_fix, iter_res;

  // Decode the incoming op: operand signs, magnitudes and special cases.
  always_comb begin
    is_mul = op_is_mul(md_op_i);
    is_rem = md_op_i inside {REM, REMU};
    sa     = op_a_signed(md_op_i) & a_i[XLEN-1];
    sb     = op_b_signed(md_op_i) & b_i[XLEN-1];
    mag_a  = sa ? -a_i : a_i;
    mag_b  = sb ? -b_i : b_i;
    ovf_in = (md_op_i inside {DIV, REM}) &&
             (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == {XLEN{1'b1}});
  end

`ifdef EX_FAST_MUL_EN
  // Single-cycle multiplier on magnitudes, sign restored immediately.
  always_comb begin
    fast     = md_en_i & is_mul;
    fast_fix = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    if (sa ^ sb) fast_fix = -fast_fix;
  end
`else
  // Every M op goes through the iterative path.
  always_comb begin
    fast     = 1'b0;
    fast_fix = '0;
  end
`endif

  // Handshake, next state and one iteration step of the datapath.
  always_comb begin
    start     = (state_q == IDLE) & valid_i & md_en_i & ~fast & ~flush_i;
    busy_o    = ((state_q == IDLE) & valid_i & md_en_i & ~fast) | (state_q == RUN);
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    rem_diff  = rem_shift - {1'b0, opnd_q};
    state_d   = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (flush_i) state_d = IDLE;
               else if (cnt_q == CNTW'(1)) state_d = DONE;
      DONE:    if (flush_i || enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counter and operand/accumulator registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      op_q       <= MUL;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        op_q       <= md_op_i;
        cnt_q      <= CNTW'(XLEN);
        opnd_q     <= is_mul ? mag_a : mag_b;
        acc_q      <= {{XLEN{1'b0}}, (is_mul ? mag_b : mag_a)};
        neg_q      <= is_rem ? sa : (sa ^ sb);
        div_zero_q <= ~is_mul & (b_i == '0);
        ovf_q      <= ovf_in;
      end else if (state_q == RUN && !flush_i) begin
        cnt_q <= cnt_q - CNTW'(1);
        if (op_is_mul(op_q))
          acc_q <= {mul_sum, acc_q[XLEN-1:1]};
        else if (rem_diff[XLEN])
          acc_q <= {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
          acc_q <= {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
    end
  end

  // Sign fix-up and special-case selection of the final result.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    q_fix    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    r_fix    = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    iter_res = '0;
    case (op_q)
      MUL:                 iter_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: iter_res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU: begin
        if (div_zero_q)  iter_res = {XLEN{DIV_ZERO_QUOT_BIT}};
        else if (ovf_q)  iter_res = {OVF_QUOT_MSB, {(XLEN-1){1'b0}}};
        else             iter_res = q_fix;
      end
      REM, REMU: begin
        if (ovf_q)       iter_res = {XLEN{OVF_REM_BIT}};
        else             iter_res = r_fix;
      end
      default:             iter_res = '0;
    endcase
    res_valid_o = (state_q == DONE) | fast;
    res_o       = fast ? (md_op_i == MUL ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN])
                       : iter_res;
  end

endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage between ID/EX and MEM. Forwarding muxes, ALU,
// branch comparator, the md_unit and the EX/MEM pipeline register.
// Build option EX_FAST_MUL_EN (see md_unit): single-cycle multiplies.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NFWD  = 2,
  parameter int RADDR = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             flush_i,
  ex_stage_md_if.slave     id_ex,
  output logic             br_eq_o,
  output logic             br_lt_o,
  output logic [XLEN-1:0]  alu_o,
  output logic [XLEN-1:0]  result_mem_o,
  output logic [XLEN-1:0]  rs2_mem_o,
  output logic [XLEN-1:0]  pc4_mem_o,
  output logic [RADDR-1:0] rd_mem_o,
  output logic             regwen_mem_o,
  output logic             memrw_mem_o,
  output logic [1:0]       wbsel_mem_o,
  output logic             valid_mem_o
);
  localparam int SELW = $clog2(NFWD + 1);
  localparam int SHW  = $clog2(XLEN);

  logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, md_res;
  logic [SHW-1:0]  shamt;
  logic            md_busy, md_res_valid;

  // Forwarding network: select 0 is the register file, k is source k.
  always_comb begin
    fwd_a = id_ex.rs1;
    fwd_b = id_ex.rs2;
    for (int k = 1; k <= NFWD; k++) begin
      if (id_ex.a_fwd_sel == SELW'(k)) fwd_a = id_ex.fwd_data[(k-1)*XLEN +: XLEN];
      if (id_ex.b_fwd_sel == SELW'(k)) fwd_b = id_ex.fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

  // ALU operand selection and the ALU proper.
  always_comb begin
    alu_a = id_ex.a_sel ? id_ex.pc : fwd_a;
    alu_b = id_ex.b_sel ? id_ex.imm : fwd_b;
    shamt = alu_b[SHW-1:0];
    alu_o = '0;
    case (id_ex.alu_op)
      ALU_ADD:    alu_o = alu_a + alu_b;
      ALU_SUB:    alu_o = alu_a - alu_b;
      ALU_SLL:    alu_o = alu_a << shamt;
      ALU_SLT:    alu_o = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU:   alu_o = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_XOR:    alu_o = alu_a ^ alu_b;
      ALU_SRL:    alu_o = alu_a >> shamt;
      ALU_SRA:    alu_o = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:     alu_o = alu_a | alu_b;
      ALU_AND:    alu_o = alu_a & alu_b;
      ALU_PASS_B: alu_o = alu_b;
      default:    alu_o = '0;
    endcase
  end

  // Branch comparator on the forwarded register operands.
  always_comb begin
    br_eq_o = (fwd_a == fwd_b);
    br_lt_o = id_ex.br_un ? (fwd_a < fwd_b) : ($signed(fwd_a) < $signed(fwd_b));
  end

  md_unit #(.XLEN(XLEN)) u_md (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (id_ex.valid),
    .md_en_i     (id_ex.md_en),
    .md_op_i     (id_ex.md_op),
    .flush_i     (flush_i),
    .enable_i    (enable_i),
    .a_i         (fwd_a),
    .b_i         (fwd_b),
    .busy_o      (md_busy),
    .res_valid_o (md_res_valid),
    .res_o       (md_res)
  );

  assign id_ex.busy = md_busy;

  // EX/MEM register: bubbles on flush or while md is busy, otherwise loads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_mem_o <= '0;
      rs2_mem_o    <= '0;
      pc4_mem_o    <= '0;
      rd_mem_o     <= '0;
      regwen_mem_o <= 1'b0;
      memrw_mem_o  <= 1'b0;
      wbsel_mem_o  <= '0;
      valid_mem_o  <= 1'b0;
    end else if (enable_i) begin
      if (flush_i || md_busy) begin
        valid_mem_o  <= 1'b0;
        regwen_mem_o <= 1'b0;
        memrw_mem_o  <= 1'b0;
      end else begin
        result_mem_o <= md_res_valid ? md_res : alu_o;
        rs2_mem_o    <= fwd_b;
        pc4_mem_o    <= id_ex.pc4;
        rd_mem_o     <= id_ex.rd;
        regwen_mem_o <= id_ex.regwen;
        memrw_mem_o  <= id_ex.memrw;
        wbsel_mem_o  <= id_ex.wbsel;
        valid_mem_o  <= id_ex.valid;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed vectors for ex_stage_md with hand-computed results.
module tb_ex_stage_md;
  import ex_pkg::*;

`ifdef EX_FAST_MUL_EN
  localparam bit FAST_BUILD = 1'b1;
`else
  localparam bit FAST_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        flush = 1'b0;
  logic        br_eq, br_lt, regwen_mem, memrw_mem, valid_mem;
  logic [31:0] alu, result_mem, rs2_mem, pc4_mem;
  logic [4:0]  rd_mem;
  logic [1:0]  wbsel_mem;
  int          total = 0;
  int          bad = 0;

  ex_stage_md_if #(.XLEN(32), .NFWD(2), .RADDR(5)) bus ();

  ex_stage_md #(.XLEN(32), .NFWD(2), .RADDR(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .flush_i      (flush),
    .id_ex        (bus),
    .br_eq_o      (br_eq),
    .br_lt_o      (br_lt),
    .alu_o        (alu),
    .result_mem_o (result_mem),
    .rs2_mem_o    (rs2_mem),
    .pc4_mem_o    (pc4_mem),
    .rd_mem_o     (rd_mem),
    .regwen_mem_o (regwen_mem),
    .memrw_mem_o  (memrw_mem),
    .wbsel_mem_o  (wbsel_mem),
    .valid_mem_o  (valid_mem)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic md_en, input md_op_e md_op,
                               input alu_op_e alu_op, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] imm,
                               input logic b_sel);
    bus.valid     = valid;
    bus.md_en     = md_en;
    bus.md_op     = md_op;
    bus.alu_op    = alu_op;
    bus.rs1       = rs1;
    bus.rs2       = rs2;
    bus.imm       = imm;
    bus.b_sel     = b_sel;
    bus.a_sel     = 1'b0;
    bus.a_fwd_sel = 2'd0;
    bus.b_fwd_sel = 2'd0;
    bus.fwd_data  = '0;
    bus.pc        = 32'h0000_1000;
    bus.pc4       = 32'h0000_1004;
    bus.br_un     = 1'b0;
    bus.rd        = 5'd7;
    bus.regwen    = 1'b1;
    bus.memrw     = 1'b0;
    bus.wbsel     = 2'd1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, MUL, ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic int expBusy(input md_op_e op);
    return (FAST_BUILD && op_is_mul(op)) ? 0 : 33;
  endfunction

  // Runs one M op to completion; leaves EX/MEM holding a 0-result bubble.
  task automatic runMd(input string tag, input md_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int n;
    applyStimulus(1'b1, 1'b1, op, ALU_ADD, a, b, 32'd0, 1'b0);
    #1;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      stepCycle();
    end
    checkOutput({tag, " busy cycles"}, n, expBusy(op));
    checkOutput({tag, " bubble"}, {31'd0, valid_mem}, 32'd0);
    stepCycle();
    checkOutput({tag, " result"}, result_mem, exp);
    checkOutput({tag, " valid"}, {31'd0, valid_mem}, 32'd1);
    idleInputs();
    stepCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic leak;
    idleInputs();
    #1 rst = 1'b1;
    #3;
    checkOutput("reset result", result_mem, 32'd0);
    checkOutput("reset valid", {31'd0, valid_mem}, 32'd0);
    checkOutput("reset regwen", {31'd0, regwen_mem}, 32'd0);
    checkOutput("reset rd", {27'd0, rd_mem}, 32'd0);
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ADD with rs1 taken from forwarding source 2, B from the immediate
    applyStimulus(1'b1, 1'b0, MUL, ALU_ADD, 32'h99, 32'h0, 32'd5, 1'b1);
    bus.a_fwd_sel = 2'd2;
    bus.fwd_data  = {32'h10, 32'h77};
    #1 checkOutput("add fwd alu_o", alu, 32'h15);
    stepCycle();
    checkOutput("add fwd result", result_mem, 32'h15);
    checkOutput("add fwd valid", {31'd0, valid_mem}, 32'd1);
    checkOutput("add fwd rd", {27'd0, rd_mem}, 32'd7);
    checkOutput("add fwd pc4", pc4_mem, 32'h1004);

    // PC-relative add
    applyStimulus(1'b1, 1'b0, MUL, ALU_ADD, 32'h0, 32'h0, 32'h20, 1'b1);
    bus.a_sel = 1'b1;
    bus.pc    = 32'h100;
    #1 checkOutput("pc add alu_o", alu, 32'h120);

    // SUB with rs2 from forwarding source 1, as a store
    applyStimulus(1'b1, 1'b0, MUL, ALU_SUB, 32'h10, 32'h5, 32'd0, 1'b0);
    bus.b_fwd_sel = 2'd1;
    bus.fwd_data  = {32'h0, 32'h30};
    bus.memrw     = 1'b1;
    #1 checkOutput("sub alu_o", alu, 32'hFFFF_FFE0);
    stepCycle();
    checkOutput("sub store data", rs2_mem, 32'h30);
    checkOutput("sub memrw", {31'd0, memrw_mem}, 32'd1);

    // Arithmetic shift and compares
    applyStimulus(1'b1, 1'b0, MUL, ALU_SRA, 32'h8000_0000, 32'h0, 32'd4, 1'b1);
    #1 checkOutput("sra alu_o", alu, 32'hF800_0000);
    applyStimulus(1'b1, 1'b0, MUL, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    #1 checkOutput("sltu alu_o", alu, 32'd0);
    checkOutput("br_lt signed", {31'd0, br_lt}, 32'd1);
    checkOutput("br_eq diff", {31'd0, br_eq}, 32'd0);
    bus.br_un = 1'b1;
    #1 checkOutput("br_lt unsigned", {31'd0, br_lt}, 32'd0);
    applyStimulus(1'b1, 1'b0, MUL, ALU_SLT, 32'd5, 32'd5, 32'd0, 1'b0);
    #1 checkOutput("br_eq same", {31'd0, br_eq}, 32'd1);
    idleInputs();
    stepCycle();

    // Multiply/divide vectors including div-by-zero and signed overflow
    runMd("div 7/0", DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
    runMd("rem 7%0", REM, 32'd7, 32'd0, 32'd7);
    runMd("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    runMd("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    runMd("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    runMd("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    runMd("mul neg", MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    runMd("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    runMd("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runMd("div neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    runMd("rem neg", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    runMd("divu", DIVU, 32'd100, 32'd7, 32'd14);
    runMd("remu", REMU, 32'd100, 32'd7, 32'd2);

    // MUL 6x7 held at completion by enable low for three cycles
    applyStimulus(1'b1, 1'b1, MUL, ALU_ADD, 32'd6, 32'd7, 32'd0, 1'b0);
    #1;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      stepCycle();
    end
    checkOutput("hold busy cycles", n, expBusy(MUL));
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("hold result", result_mem, 32'd0);
      checkOutput("hold valid", {31'd0, valid_mem}, 32'd0);
    end
    enable = 1'b1;
    stepCycle();
    checkOutput("hold release result", result_mem, 32'd42);
    checkOutput("hold release valid", {31'd0, valid_mem}, 32'd1);
    idleInputs();
    stepCycle();

    // Flush on cycle 10 of a DIVU
    applyStimulus(1'b1, 1'b1, DIVU, ALU_ADD, 32'd100, 32'd7, 32'd0, 1'b0);
    repeat (10) stepCycle();
    checkOutput("flush busy before", {31'd0, bus.busy}, 32'd1);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    idleInputs();
    #1;
    checkOutput("flush busy after", {31'd0, bus.busy}, 32'd0);
    checkOutput("flush valid", {31'd0, valid_mem}, 32'd0);
    leak = 1'b0;
    repeat (40) begin
      stepCycle();
      leak = leak | valid_mem | (result_mem != 32'd0);
    end
    checkOutput("flush no late result", {31'd0, leak}, 32'd0);

    // Flush arriving together with DONE drops the result
    applyStimulus(1'b1, 1'b1, DIVU, ALU_ADD, 32'd100, 32'd7, 32'd0, 1'b0);
    #1;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      stepCycle();
    end
    checkOutput("flush@done busy cycles", n, 33);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    idleInputs();
    checkOutput("flush@done valid", {31'd0, valid_mem}, 32'd0);
    checkOutput("flush@done result", result_mem, 32'd0);
    stepCycle();
    checkOutput("flush@done later", result_mem, 32'd0);

    // Asynchronous reset in the middle of a DIV
    applyStimulus(1'b1, 1'b0, MUL, ALU_ADD, 32'h55, 32'd0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("pre-reset result", result_mem, 32'h55);
    applyStimulus(1'b1, 1'b1, DIV, ALU_ADD, 32'd100, 32'd3, 32'd0, 1'b0);
    repeat (5) stepCycle();
    #2;
    rst = 1'b1;
    idleInputs();
    #1;
    checkOutput("async rst result", result_mem, 32'd0);
    checkOutput("async rst valid", {31'd0, valid_mem}, 32'd0);
    checkOutput("async rst busy", {31'd0, bus.busy}, 32'd0);
    stepCycle();
    rst = 1'b0;
    leak = 1'b0;
    repeat (40) begin
      stepCycle();
      leak = leak | valid_mem | (result_mem != 32'd0);
    end
    checkOutput("async rst no result", {31'd0, leak}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
